// File: rtl/bode_response_analyzer_if.sv
// Excitation/response/result bundle for bode_response_analyzer.
// The analyzer connects through the slave modport; a driver uses the master modport.
interface bode_response_analyzer_if #(
   parameter int EXCITE_WIDTH   = 16,
   parameter int RESPONSE_WIDTH = 16,
   parameter int ACC_WIDTH      = 48
);
   logic                             en;
   logic                             start;
   logic signed [EXCITE_WIDTH-1:0]   sinRef;
   logic signed [EXCITE_WIDTH-1:0]   cosRef;
   logic signed [RESPONSE_WIDTH-1:0] response;
   logic signed [ACC_WIDTH-1:0]      iAcc;
   logic signed [ACC_WIDTH-1:0]      qAcc;
   logic                             busy;
   logic                             resultStrobe;
   logic                             overflow;

   modport master (
      output en, start, sinRef, cosRef, response,
      input  iAcc, qAcc, busy, resultStrobe, overflow
   );

   modport slave (
      input  en, start, sinRef, cosRef, response,
      output iAcc, qAcc, busy, resultStrobe, overflow
   );
endinterface

// File: rtl/bode_response_analyzer.sv
// Single-tone I/Q correlator: settle, accumulate response*sin / response*cos, report.
// Define BODE_ANALYZER_SAT_EN for saturating accumulators with a sticky overflow flag.
module bode_response_analyzer #(
   parameter int EXCITE_WIDTH   = 16,
   parameter int RESPONSE_WIDTH = 16,
   parameter int ACC_WIDTH      = 48,
   parameter int NUM_SETTLE     = 256,
   parameter int NUM_SAMPLES    = 1024
) (
   input logic                     clk,
   input logic                     rst,
   bode_response_analyzer_if.slave bus
);
   localparam int PROD_WIDTH = EXCITE_WIDTH + RESPONSE_WIDTH;
   localparam int CNT_MAX    = (NUM_SETTLE > NUM_SAMPLES) ? NUM_SETTLE : NUM_SAMPLES;
   localparam int CNT_WIDTH  = $clog2(CNT_MAX + 1);
   localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'((NUM_SETTLE > 0) ? NUM_SETTLE - 1 : 0);
   localparam logic [CNT_WIDTH-1:0] SAMPLE_LAST = CNT_WIDTH'(NUM_SAMPLES - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, FLUSH, DONE} state_t;

   state_t                       r_state, w_next;
   logic [CNT_WIDTH-1:0]         r_cnt, w_cnt_next;
   logic                         w_clear, w_sample, w_done_entry;
   logic signed [PROD_WIDTH-1:0] r_prod_i, r_prod_q;
   logic                         r_prod_valid;
   logic signed [ACC_WIDTH-1:0]  r_acc_i, r_acc_q, w_sum_i, w_sum_q;
   logic                         w_ovf_i, w_ovf_q;
   logic                         r_ovf, r_strobe;

`ifdef BODE_ANALYZER_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   // One guard bit catches the overflow; its sign picks the rail to clamp to.
   function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0]  a,
                                                  input logic signed [PROD_WIDTH-1:0] p);
      logic signed [ACC_WIDTH:0] s;
      s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(p);
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
         return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
      return {1'b0, s[ACC_WIDTH-1:0]};
   endfunction
`else
   function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0]  a,
                                                  input logic signed [PROD_WIDTH-1:0] p);
      return {1'b0, a + ACC_WIDTH'(p)};
   endfunction
`endif

   always_comb begin
      {w_ovf_i, w_sum_i} = acc_add(r_acc_i, r_prod_i);
      {w_ovf_q, w_sum_q} = acc_add(r_acc_q, r_prod_q);
   end

   always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt;
      w_clear      = 1'b0;
      w_sample     = 1'b0;
      w_done_entry = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_clear    = 1'b1;
               w_cnt_next = '0;
               w_next     = (NUM_SETTLE == 0) ? ACCUM : SETTLE;
            end
         end
         SETTLE: begin
            if (bus.en) begin
               if (r_cnt == SETTLE_LAST) begin
                  w_cnt_next = '0;
                  w_next     = ACCUM;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         ACCUM: begin
            if (bus.en) begin
               w_sample = 1'b1;
               if (r_cnt == SAMPLE_LAST) begin
                  w_cnt_next = '0;
                  w_next     = FLUSH;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         FLUSH: begin
            // The final product lands in the accumulator the cycle its valid bit drops.
            if (!r_prod_valid) begin
               w_next       = DONE;
               w_done_entry = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_prod_i     <= '0;
         r_prod_q     <= '0;
         r_prod_valid <= 1'b0;
         r_acc_i      <= '0;
         r_acc_q      <= '0;
         r_ovf        <= 1'b0;
         r_strobe     <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_cnt        <= w_cnt_next;
         r_strobe     <= w_done_entry;
         r_prod_valid <= w_sample;
         if (w_sample) begin
            r_prod_i <= PROD_WIDTH'(bus.response) * PROD_WIDTH'(bus.sinRef);
            r_prod_q <= PROD_WIDTH'(bus.response) * PROD_WIDTH'(bus.cosRef);
         end
         if (w_clear) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_ovf   <= 1'b0;
         end else if (r_prod_valid) begin
            r_acc_i <= w_sum_i;
            r_acc_q <= w_sum_q;
            r_ovf   <= r_ovf | w_ovf_i | w_ovf_q;
         end
      end
   end

   assign bus.iAcc         = r_acc_i;
   assign bus.qAcc         = r_acc_q;
   assign bus.busy         = (r_state == SETTLE) || (r_state == ACCUM) || (r_state == FLUSH);
   assign bus.resultStrobe = r_strobe;
   assign bus.overflow     = r_ovf;
endmodule

// File: tb/tb_bode_response_analyzer.sv
// Bench for bode_response_analyzer: three configurations checked against a
// transaction-level correlation model (honours BODE_ANALYZER_SAT_EN).
module tb_bode_response_analyzer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              drv_en, drv_start;
   logic [1:0]        sel;
   logic signed [15:0] drv_sin, drv_cos, drv_resp;
   int n_checks = 0;
   int n_errors = 0;

   bode_response_analyzer_if #(.ACC_WIDTH(48)) bA ();
   bode_response_analyzer_if #(.ACC_WIDTH(32)) bB ();
   bode_response_analyzer_if #(.ACC_WIDTH(48)) bC ();

   assign bA.en = drv_en;  assign bA.start = drv_start && (sel == 2'd0);
   assign bA.sinRef = drv_sin;  assign bA.cosRef = drv_cos;  assign bA.response = drv_resp;
   assign bB.en = drv_en;  assign bB.start = drv_start && (sel == 2'd1);
   assign bB.sinRef = drv_sin;  assign bB.cosRef = drv_cos;  assign bB.response = drv_resp;
   assign bC.en = drv_en;  assign bC.start = drv_start && (sel == 2'd2);
   assign bC.sinRef = drv_sin;  assign bC.cosRef = drv_cos;  assign bC.response = drv_resp;

   bode_response_analyzer #(.ACC_WIDTH(48), .NUM_SETTLE(2), .NUM_SAMPLES(4))
      dut_a (.clk(clk), .rst(rst), .bus(bA.slave));
   bode_response_analyzer #(.ACC_WIDTH(32), .NUM_SETTLE(2), .NUM_SAMPLES(4))
      dut_b (.clk(clk), .rst(rst), .bus(bB.slave));
   bode_response_analyzer #(.ACC_WIDTH(48), .NUM_SETTLE(0), .NUM_SAMPLES(1))
      dut_c (.clk(clk), .rst(rst), .bus(bC.slave));

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint get_i(input int s);
      case (s)
         0:       return longint'(bA.iAcc);
         1:       return longint'(bB.iAcc);
         default: return longint'(bC.iAcc);
      endcase
   endfunction
   function automatic longint get_q(input int s);
      case (s)
         0:       return longint'(bA.qAcc);
         1:       return longint'(bB.qAcc);
         default: return longint'(bC.qAcc);
      endcase
   endfunction
   function automatic longint get_busy(input int s);
      case (s)
         0:       return longint'(bA.busy);
         1:       return longint'(bB.busy);
         default: return longint'(bC.busy);
      endcase
   endfunction
   function automatic longint get_strobe(input int s);
      case (s)
         0:       return longint'(bA.resultStrobe);
         1:       return longint'(bB.resultStrobe);
         default: return longint'(bC.resultStrobe);
      endcase
   endfunction
   function automatic longint get_ovf(input int s);
      case (s)
         0:       return longint'(bA.overflow);
         1:       return longint'(bB.overflow);
         default: return longint'(bC.overflow);
      endcase
   endfunction

   // Reference accumulation: exact sum, then wrap to w bits or clamp to the w-bit range.
   function automatic longint acc_step(input longint acc, input longint p, input int w,
                                       inout bit ovf);
      longint sum, mx, mn;
      sum = acc + p;
      mx  = (longint'(1) <<< (w - 1)) - 1;
      mn  = -(longint'(1) <<< (w - 1));
`ifdef BODE_ANALYZER_SAT_EN
      if (sum > mx) begin ovf = 1'b1; return mx; end
      if (sum < mn) begin ovf = 1'b1; return mn; end
      return sum;
`else
      if (mx < mn) ovf = 1'b1;
      return (sum <<< (64 - w)) >>> (64 - w);
`endif
   endfunction

   function automatic logic signed [15:0] pick(input bit rnd, input logic signed [15:0] v);
      return rnd ? 16'($urandom) : v;
   endfunction

   // per: 0 = random en, N = en when cycle index is a multiple of N (cycle 0 = start cycle).
   task automatic run_meas(input int s, input int per, input bit rnd,
                           input logic signed [15:0] r0, input logic signed [15:0] s0,
                           input logic signed [15:0] c0, input bit extra_start, input string tag);
      int nset, nsamp, accw, cnt, last, t;
      longint ei, eq;
      bit eovf, seen, e;
      nset  = (s == 2) ? 0 : 2;
      nsamp = (s == 2) ? 1 : 4;
      accw  = (s == 1) ? 32 : 48;
      ei = 0; eq = 0; eovf = 1'b0; cnt = 0; last = -1; seen = 1'b0; t = 0;
      sel       = 2'(s);
      drv_start = 1'b1;
      drv_en    = (per == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      drv_resp  = pick(rnd, r0);
      drv_sin   = pick(rnd, s0);
      drv_cos   = pick(rnd, c0);
      while (!seen && t < 200) begin
         @(posedge clk); #1; t++;
         check({tag, ".busy"}, get_busy(s),
               longint'((last < 0) || (t < last + 3)));
         check({tag, ".strobe"}, get_strobe(s),
               longint'((last >= 0) && (t == last + 3)));
         if (get_strobe(s) != 0) seen = 1'b1;
         drv_start = extra_start && (t == 2);
         e         = (per == 0) ? 1'($urandom_range(0, 1)) : ((t % per) == 0);
         drv_en    = e;
         drv_resp  = pick(rnd, r0);
         drv_sin   = pick(rnd, s0);
         drv_cos   = pick(rnd, c0);
         if (e && cnt < nset + nsamp) begin
            cnt++;
            if (cnt > nset) begin
               ei = acc_step(ei, longint'(drv_resp) * longint'(drv_sin), accw, eovf);
               eq = acc_step(eq, longint'(drv_resp) * longint'(drv_cos), accw, eovf);
            end
            if (cnt == nset + nsamp) last = t;
         end
      end
      check({tag, ".strobe_seen"}, longint'(seen), 1);
      check({tag, ".iacc"}, get_i(s), ei);
      check({tag, ".qacc"}, get_q(s), eq);
      check({tag, ".ovf"}, get_ovf(s), longint'(eovf));
      drv_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drv_en   = 1'($urandom_range(0, 1));
         drv_resp = 16'($urandom);
         drv_sin  = 16'($urandom);
         @(posedge clk); #1;
         check({tag, ".no_restrobe"}, get_strobe(s), 0);
      end
      check({tag, ".hold_i"}, get_i(s), ei);
      check({tag, ".hold_busy"}, get_busy(s), 0);
   endtask

   task automatic reset_mid();
      int strobes;
      sel = 2'd0; drv_start = 1'b1; drv_en = 1'b1;
      drv_resp = 16'sd100; drv_sin = 16'sd1000; drv_cos = -16'sd500;
      for (int t = 1; t <= 5; t++) begin
         @(posedge clk); #1;
         drv_start = 1'b0;
      end
      check("r038.busy_before", get_busy(0), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("r038.iacc", get_i(0), 0);
      check("r038.qacc", get_q(0), 0);
      check("r038.busy", get_busy(0), 0);
      check("r038.strobe", get_strobe(0), 0);
      check("r038.ovf", get_ovf(0), 0);
      rst = 1'b0;
      strobes = 0;
      for (int t = 0; t < 12; t++) begin
         @(posedge clk); #1;
         if (get_strobe(0) != 0) strobes++;
      end
      check("r038.no_strobe", longint'(strobes), 0);
   endtask

   initial begin
      rst = 1'b1; drv_en = 1'b1; drv_start = 1'b1; sel = 2'd0;
      drv_sin = '0; drv_cos = '0; drv_resp = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         check("reset.iacc", get_i(s), 0);
         check("reset.busy", get_busy(s), 0);
         check("reset.strobe", get_strobe(s), 0);
         check("reset.ovf", get_ovf(s), 0);
      end
      rst = 1'b0; drv_start = 1'b0; drv_en = 1'b0;
      @(posedge clk); #1;

      run_meas(0, 1, 1'b0, 16'sd100, 16'sd1000, 16'sd0, 1'b0, "r035");
      check("r035.iacc_const", get_i(0), 400000);
      run_meas(0, 3, 1'b0, 16'sd100, 16'sd1000, -16'sd500, 1'b0, "r036");
      check("r036.qacc_const", get_q(0), -200000);
      run_meas(0, 1, 1'b0, 16'sd100, 16'sd1000, 16'sd0, 1'b1, "r037");
      check("r037.iacc_const", get_i(0), 400000);
      reset_mid();
      run_meas(0, 1, 1'b0, 16'sd100, 16'sd1000, -16'sd500, 1'b0, "r038b");
      run_meas(1, 1, 1'b0, 16'sd32767, 16'sd32767, 16'sd0, 1'b0, "r039");
`ifdef BODE_ANALYZER_SAT_EN
      check("r039.iacc_const", get_i(1), 2147483647);
      check("r039.ovf_const", get_ovf(1), 1);
`else
      check("r039.iacc_const", get_i(1), -262140);
      check("r039.ovf_const", get_ovf(1), 0);
`endif
      run_meas(1, 1, 1'b0, 16'sd100, 16'sd1000, 16'sd0, 1'b0, "r039b");
      run_meas(2, 1, 1'b0, -16'sd32768, -16'sd32768, -16'sd32768, 1'b0, "r040");
      check("r040.iacc_const", get_i(2), 1073741824);
      for (int k = 0; k < 12; k++)
         run_meas(k % 3, int'($urandom_range(0, 3)), 1'b1, 16'sd0, 16'sd0, 16'sd0,
                  1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/bode_response_analyzer.md
BODE_RESPONSE_ANALYZER -- requirements
Module: bode_response_analyzer

Interface
REQ-001 SHALL have parameter EXCITE_WIDTH, default 16, meaning signed width of the sin/cos reference samples.
REQ-002 SHALL have parameter RESPONSE_WIDTH, default 16, meaning signed width of the DUT response sample.
REQ-003 SHALL have parameter ACC_WIDTH, default 48, meaning signed width of each correlation accumulator.
REQ-004 SHALL have parameter NUM_SETTLE, default 256, meaning sample strobes discarded before accumulation (0 is legal).
REQ-005 SHALL have parameter NUM_SAMPLES, default 1024, meaning sample strobes accumulated (at least 1).
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-008 SHALL have port en, input, 1, meaning sample strobe; inputs are valid in each cycle it is high.
REQ-009 SHALL have port start, input, 1, meaning begin one measurement.
REQ-010 SHALL have port sinRef, input, EXCITE_WIDTH signed, meaning sine excitation currently driven.
REQ-011 SHALL have port cosRef, input, EXCITE_WIDTH signed, meaning cosine excitation currently driven.
REQ-012 SHALL have port response, input, RESPONSE_WIDTH signed, meaning measured DUT output.
REQ-013 SHALL have port iAcc, output, ACC_WIDTH signed, meaning sum of response*sinRef.
REQ-014 SHALL have port qAcc, output, ACC_WIDTH signed, meaning sum of response*cosRef.
REQ-015 SHALL have port busy, output, 1, meaning a measurement is in progress.
REQ-016 SHALL have port resultStrobe, output, 1, meaning a one-cycle pulse when iAcc/qAcc are final.
REQ-017 SHALL have port overflow, output, 1, meaning sticky accumulator saturation flag.

Function
REQ-018 SHALL implement the FSM states IDLE, SETTLE, ACCUM, FLUSH and DONE.
REQ-019 SHALL, in IDLE with start=1, clear iAcc, qAcc, overflow and the sample counter, and enter SETTLE on the next cycle (ACCUM if NUM_SETTLE=0).
REQ-020 SHALL ignore start in all states other than IDLE and DONE.
REQ-021 SHALL count en cycles in SETTLE without accumulating, and enter ACCUM on the cycle after the NUM_SETTLE-th en.
REQ-022 SHALL, for each en in ACCUM, register the products response*sinRef and response*cosRef (full width EXCITE_WIDTH+RESPONSE_WIDTH, signed) plus a valid bit: pipeline stage 1.
REQ-023 SHALL, one cycle after stage 1, add each sign-extended product into its accumulator: stage 2; the latency from en to the accumulator update is 2 cycles.
REQ-024 SHALL enter FLUSH after the NUM_SAMPLES-th en in ACCUM, and ignore en in FLUSH, DONE and IDLE.
REQ-025 SHALL remain in FLUSH exactly until the last product has been accumulated, then enter DONE.
REQ-026 SHALL assert resultStrobe for exactly the one cycle in which DONE is entered, then hold iAcc/qAcc stable.
REQ-027 SHALL, in DONE, go to SETTLE/ACCUM on start (as in REQ-019), and otherwise remain in DONE holding the results.
REQ-028 SHALL drive busy=1 in SETTLE, ACCUM and FLUSH, and 0 otherwise.
REQ-029 SHALL handle en=1 in the same cycle as start as not counted; counting begins the next cycle.
REQ-030 SHALL handle the extreme inputs (-2^(W-1)) x (-2^(W-1)) exactly with no product-stage overflow.

Reset
REQ-031 SHALL, when rst=1, force state IDLE and drive iAcc=0, qAcc=0, busy=0, resultStrobe=0 and overflow=0, with counters and product registers cleared on the next edge.
REQ-032 SHALL give rst priority over start and en, abandon any measurement in progress, and not emit resultStrobe for it.

Configuration
REQ-033 SHALL, with macro BODE_ANALYZER_SAT_EN defined, clamp each accumulator to +/-(2^(ACC_WIDTH-1)) bounds on overflow and set overflow until the next start or reset.
REQ-034 SHALL, without BODE_ANALYZER_SAT_EN, wrap the accumulators modulo 2^ACC_WIDTH and tie overflow to 0.

Verification
REQ-035 SHALL cover: NUM_SETTLE=2, NUM_SAMPLES=4, response=100, sinRef=1000, cosRef=0, en every cycle -> iAcc=400000, qAcc=0, one resultStrobe 9 cycles after start.
REQ-036 SHALL cover: same setup, cosRef=-500, en every third cycle -> qAcc=-200000, with busy high throughout and no early strobe.
REQ-037 SHALL cover: start pulsed again while busy -> ignored, with results identical to REQ-035.
REQ-038 SHALL cover: rst asserted during ACCUM -> all outputs 0 next cycle, no resultStrobe; a new start measures correctly.
REQ-039 SHALL cover: ACC_WIDTH=32, response=32767, sinRef=32767, NUM_SAMPLES=4 -> with macro iAcc=2147483647 and overflow=1; without macro iAcc wraps to 4294705156 mod 2^32 (signed: -262140) and overflow=0.
REQ-040 SHALL cover: NUM_SETTLE=0, NUM_SAMPLES=1, response=-32768, sinRef=-32768 -> iAcc=1073741824 after a single en.
